lcd_char_ctrl: RTL and testbench



---
 rtl/lcd_char_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lcd_char_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_ctrl.sv
// HD44780-style character LCD controller: power-up wait, init commands, then continuous
// refresh of a ROWS x COLS character buffer over the 8-bit parallel bus.
module lcd_char_ctrl #(
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int EN_CYCLES  = 25,
  parameter int CMD_WAIT   = 2500,
  parameter int CLR_WAIT   = 100000,
  parameter int PWRUP_WAIT = 2500000,
  localparam int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          bl_on,
  output logic          ready,
  output logic          frame_done,
  output logic [7:0]    LCD_DATA,
  output logic          LCD_RW,
  output logic          LCD_EN,
  output logic          LCD_RS,
  output logic          LCD_ON,
  output logic          LCD_BLON
);

  // state    | meaning
  // ST_PWRUP | idle after reset for PWRUP_WAIT cycles
  // ST_SETUP | RS/DATA presented, EN low (1 cycle)
  // ST_PULSE | EN high for EN_CYCLES cycles
  // ST_WAIT  | EN low for CMD_WAIT (CLR_WAIT after clear) cycles
  // phase_q selects what the transaction carries: init command, row address, or character.

  localparam int DEPTH = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TM1   = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
  localparam int TM2   = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
  localparam int TMAX  = (TM1 > TM2) ? TM1 : TM2;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [1:0] {ST_PWRUP, ST_SETUP, ST_PULSE, ST_WAIT} state_t;
  typedef enum logic [1:0] {PH_INIT, PH_ADDR, PH_CHAR} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [1:0]      init_idx_q, init_idx_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      lcd_data_q, lcd_data_d;
  logic            lcd_rs_q, lcd_rs_d;
  logic            lcd_en_q, lcd_en_d;
  logic            ready_q, ready_d;
  logic            frame_done_q, frame_done_d;
  logic            blon_q, blon_d;
  logic [7:0]      buf_q [DEPTH];

  logic            tc, is_clear, step, last_col, last_row;
  logic [1:0]      row_sel;
  logic [AW-1:0]   rd_idx;

  assign tc       = (timer_q == '0);
  assign is_clear = (phase_q == PH_INIT) && (init_idx_q == 2'd3);
  assign step     = (state_q == ST_WAIT) && tc;
  assign last_col = (col_q == CW'(COLS - 1));
  assign last_row = (row_q == RW'(ROWS - 1));
  assign row_sel  = 2'(row_d);
  assign rd_idx   = AW'(32'(row_d) * COLS + 32'(col_d));

  // Buffer is written in any state; only reset overrides a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'h20;
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_PWRUP;
      phase_q      <= PH_INIT;
      init_idx_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      timer_q      <= TW'(PWRUP_WAIT - 1);
      lcd_data_q   <= 8'h00;
      lcd_rs_q     <= 1'b0;
      lcd_en_q     <= 1'b0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      blon_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      init_idx_q   <= init_idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      timer_q      <= timer_d;
      lcd_data_q   <= lcd_data_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_en_q     <= lcd_en_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      blon_q       <= blon_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    init_idx_d = init_idx_q;
    row_d      = row_q;
    col_d      = col_q;
    timer_d    = timer_q - TW'(1);
    case (state_q)
      ST_PWRUP: if (tc) state_d = ST_SETUP;
      ST_SETUP: begin
        state_d = ST_PULSE;
        timer_d = TW'(EN_CYCLES - 1);
      end
      ST_PULSE: if (tc) begin
        state_d = ST_WAIT;
        timer_d = is_clear ? TW'(CLR_WAIT - 1) : TW'(CMD_WAIT - 1);
      end
      ST_WAIT: if (tc) begin
        state_d = ST_SETUP;
        case (phase_q)
          PH_INIT: begin
            if (init_idx_q == 2'd3) begin
              phase_d = PH_ADDR;
              row_d   = '0;
            end else begin
              init_idx_d = init_idx_q + 2'd1;
            end
          end
          PH_ADDR: begin
            phase_d = PH_CHAR;
            col_d   = '0;
          end
          default: begin
            if (last_col) begin
              col_d   = '0;
              phase_d = PH_ADDR;
              row_d   = last_row ? '0 : row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        endcase
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // The byte is latched on entry to SETUP, so a write landing during SETUP waits a pass.
  always_comb begin
    lcd_data_d   = lcd_data_q;
    lcd_rs_d     = lcd_rs_q;
    lcd_en_d     = (state_d == ST_PULSE);
    ready_d      = ready_q | (step && is_clear);
    frame_done_d = step && (phase_q == PH_CHAR) && last_col && last_row;
    blon_d       = bl_on;
    if (state_d == ST_SETUP) begin
      lcd_rs_d = (phase_d == PH_CHAR);
      case (phase_d)
        PH_INIT: begin
          case (init_idx_d)
            2'd0:    lcd_data_d = 8'h38;
            2'd1:    lcd_data_d = 8'h0C;
            2'd2:    lcd_data_d = 8'h06;
            default: lcd_data_d = 8'h01;
          endcase
        end
        PH_ADDR: begin
          case (row_sel)
            2'd0:    lcd_data_d = 8'h80;
            2'd1:    lcd_data_d = 8'hC0;
            2'd2:    lcd_data_d = 8'h94;
            default: lcd_data_d = 8'hD4;
          endcase
        end
        default: lcd_data_d = buf_q[rd_idx];
      endcase
    end
  end

  assign LCD_DATA   = lcd_data_q;
  assign LCD_RS     = lcd_rs_q;
  assign LCD_EN     = lcd_en_q;
  assign LCD_RW     = 1'b0;
  assign LCD_ON     = 1'b1;
  assign LCD_BLON   = blon_q;
  assign ready      = ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Bench for lcd_char_ctrl: scoreboard of expected bus bytes plus timing monitors on a 4x2
// instance, and a table-driven range/ordering check on a 3x2 instance.
module tb_lcd_char_ctrl;

  localparam int COLS = 4, ROWS = 2, ENC = 2, CMDW = 4, CLRW = 10, PW = 20;
  localparam int T     = 1 + ENC + CMDW;
  localparam int TC    = 1 + ENC + CLRW;
  localparam int FA    = PW + 3 * T + TC;           // cycle of first ADDR setup (= ready rise)
  localparam int FRAME = ROWS * (COLS + 1) * T;

  logic       clock, reset, wr_en, bl_on;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       ready, frame_done, LCD_RW, LCD_EN, LCD_RS, LCD_ON, LCD_BLON;
  logic [7:0] LCD_DATA;

  logic       wr_en2;
  logic [2:0] wr_addr2;
  logic [7:0] wr_data2;
  logic       ready2, frame_done2, rw2, en2, rs2, on2, blon2;
  logic [7:0] data2;

  lcd_char_ctrl #(.COLS(COLS), .ROWS(ROWS), .EN_CYCLES(ENC), .CMD_WAIT(CMDW),
                  .CLR_WAIT(CLRW), .PWRUP_WAIT(PW)) u_dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bl_on(bl_on), .ready(ready), .frame_done(frame_done), .LCD_DATA(LCD_DATA),
    .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON));

  // 3x2 buffer leaves addresses 6 and 7 representable but out of range.
  lcd_char_ctrl #(.COLS(3), .ROWS(2), .EN_CYCLES(ENC), .CMD_WAIT(CMDW),
                  .CLR_WAIT(CLRW), .PWRUP_WAIT(PW)) u_dut2 (
    .clock(clock), .reset(reset), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .bl_on(1'b0), .ready(ready2), .frame_done(frame_done2), .LCD_DATA(data2),
    .LCD_RW(rw2), .LCD_EN(en2), .LCD_RS(rs2), .LCD_ON(on2), .LCD_BLON(blon2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = -1;

  logic [8:0] sb_q [$];
  logic [8:0] cap2 [$];

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [8:0] exp;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  logic       last_clr = 1'b0;

  task automatic sb_check();
    logic [8:0] e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_extra: got %0h want none (cyc %0d)", {LCD_RS, LCD_DATA}, cyc);
      last_clr = 1'b0;
    end else begin
      e = sb_q.pop_front();
      chk("sb_byte", 32'({LCD_RS, LCD_DATA}), 32'(e));
      last_clr = (e == 9'h001);
    end
  endtask

  task automatic push_init();
    sb_q.push_back(9'h038);
    sb_q.push_back(9'h00C);
    sb_q.push_back(9'h006);
    sb_q.push_back(9'h001);
  endtask

  task automatic push_pass(input logic [7:0] c0, input logic [7:0] c5);
    sb_q.push_back(9'h080);
    sb_q.push_back({1'b1, c0});
    for (int i = 0; i < 3; i++) sb_q.push_back(9'h120);
    sb_q.push_back(9'h0C0);
    sb_q.push_back(9'h120);
    sb_q.push_back({1'b1, c5});
    for (int i = 0; i < 2; i++) sb_q.push_back(9'h120);
  endtask

  // Bus monitor on the 4x2 instance.
  logic       prev_en = 0, prev_rs = 0, prev_ready = 0, prev_fd = 0, prev_en2 = 0;
  logic [7:0] prev_data = 0;
  logic       had_fall = 0, pend = 0, fd_seen = 0, first_pend = 1;
  int         high_cnt = 0, low_cnt = 0, last_fd = 0;

  always @(negedge clock) begin
    if (reset) begin
      if (LCD_EN === 1'b1 && !prev_en) sb_check();
      cyc = -1;
      prev_en = 0; prev_rs = 0; prev_data = 8'h00; prev_ready = 0; prev_fd = 0;
      had_fall = 0; pend = 0; fd_seen = 0; first_pend = 1; high_cnt = 0; low_cnt = 0;
    end else begin
      cyc++;
      if (cyc < PW) chk("pwrup_en_low", 32'(LCD_EN), 32'd0);
      if (pend) begin
        chk("data_change_not_setup", 32'(LCD_EN && !prev_en), 32'd1);
        pend = 0;
      end
      if ({LCD_RS, LCD_DATA} !== {prev_rs, prev_data}) begin
        chk("data_change_en_high", 32'(LCD_EN), 32'd0);
        pend = 1;
      end
      if (LCD_EN && !prev_en) begin
        if (first_pend) chk("first_en_rise_cyc", cyc, PW + 1);
        first_pend = 0;
        if (had_fall) chk("en_low_width", low_cnt, last_clr ? CLRW + 1 : CMDW + 1);
        sb_check();
        high_cnt = 1;
      end else if (LCD_EN) begin
        high_cnt++;
      end else if (prev_en) begin
        chk("en_high_width", high_cnt, ENC);
        had_fall = 1;
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      if (ready && !prev_ready) chk("ready_rise_cyc", cyc, FA);
      if (frame_done) begin
        chk("frame_done_width", 32'(prev_fd), 32'd0);
        if (fd_seen) chk("frame_period", cyc - last_fd, FRAME);
        else chk("first_frame_done_cyc", cyc, FA + FRAME);
        fd_seen = 1;
        last_fd = cyc;
      end
      prev_en = LCD_EN; prev_rs = LCD_RS; prev_data = LCD_DATA;
      prev_ready = ready; prev_fd = frame_done;
    end
  end

  always @(negedge clock) begin
    if (!reset && en2 && !prev_en2 && cap2.size() < 12) cap2.push_back({rs2, data2});
    prev_en2 = reset ? 1'b0 : en2;
  end

  task automatic wait_start(input int n);
    int guard = 0;
    while (cyc != n - 1 && guard < 1000) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (guard >= 1000) chk("wait_timeout", cyc, n - 1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_en"},    32'(LCD_EN),     32'd0);
    chk({tag, "_rs"},    32'(LCD_RS),     32'd0);
    chk({tag, "_data"},  32'(LCD_DATA),   32'd0);
    chk({tag, "_ready"}, 32'(ready),      32'd0);
    chk({tag, "_fd"},    32'(frame_done), 32'd0);
    chk({tag, "_blon"},  32'(LCD_BLON),   32'd0);
    chk({tag, "_rw"},    32'(LCD_RW),     32'd0);
    chk({tag, "_on"},    32'(LCD_ON),     32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'd6, 8'h55, 9'h038};
    vecs[1]  = '{1'b1, 3'd7, 8'h55, 9'h00C};
    vecs[2]  = '{1'b1, 3'd2, 8'h41, 9'h006};
    vecs[3]  = '{1'b1, 3'd5, 8'h42, 9'h001};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 9'h080};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 9'h120};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 9'h120};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 9'h141};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 9'h0C0};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 9'h120};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 9'h120};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 9'h142};

    reset = 1; wr_en = 0; wr_addr = '0; wr_data = '0; bl_on = 0;
    wr_en2 = 0; wr_addr2 = '0; wr_data2 = '0;
    repeat (3) @(posedge clock);
    #1 reset = 0;

    push_init();
    push_pass(8'h48, 8'h69);
    push_pass(8'h48, 8'h69);
    push_pass(8'h5A, 8'h69);
    sb_q.push_back(9'h080);
    sb_q.push_back(9'h15A);

    @(negedge clock);
    #1 check_reset_state("rst_release");

    wait_start(12);
    bl_on = 1;
    @(negedge clock);
    #1 chk("blon_latency0", 32'(LCD_BLON), 32'd0);
    @(negedge clock);
    #1 chk("blon_latency1", 32'(LCD_BLON), 32'd1);

    wait_start(30);
    wr_en = 1; wr_addr = 3'd0; wr_data = 8'h48;
    @(posedge clock); #1;
    wr_addr = 3'd5; wr_data = 8'h69;
    @(posedge clock); #1;
    wr_en = 0;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        wr_en2 = 1; wr_addr2 = vecs[i].addr; wr_data2 = vecs[i].wdata;
        @(posedge clock); #1;
      end
    end
    wr_en2 = 0;

    // Write lands in the SETUP cycle of pass 2's first character.
    wait_start(FA + FRAME + T);
    wr_en = 1; wr_addr = 3'd0; wr_data = 8'h5A;
    @(posedge clock); #1;
    wr_en = 0;

    // Reset during the first EN-high cycle of pass 4's first character.
    wait_start(FA + 3 * FRAME + T + 1);
    reset = 1;
    @(negedge clock);
    #1 chk("sb_drained_before_reset", sb_q.size(), 0);
    @(posedge clock);
    #1 reset = 0;
    push_init();
    push_pass(8'h20, 8'h20);
    sb_q.push_back(9'h080);
    @(negedge clock);
    #1 check_reset_state("mid_reset");

    wait_start(FA + FRAME + 2);
    chk("sb_drained_end", sb_q.size(), 0);

    for (int i = 0; i < 12; i++) begin
      if (i < cap2.size()) chk("range_tbl_byte", 32'(cap2[i]), 32'(vecs[i].exp));
      else chk("range_tbl_missing", i, cap2.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
